// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_pkg
// Description : Shared definitions for the shift-add multiplier scheduler.
//               Holds the 3-bit state encoding and a width helper that
//               never returns less than one bit.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sm_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_TEST  = 3'd2;
    localparam logic [2:0] c_ST_ADD   = 3'd3;
    localparam logic [2:0] c_ST_SHIFT = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_LOAD  = c_ST_LOAD,
        ST_TEST  = c_ST_TEST,
        ST_ADD   = c_ST_ADD,
        ST_SHIFT = c_ST_SHIFT,
        ST_DONE  = c_ST_DONE
    } state_t;

    // ceil(log2(n)), but at least 1 so a single requester still has an id bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sm_rr_arbiter
// Description : Round-robin winner selection for the multiplier scheduler.
//               The search starts at the rotating pointer and wraps from
//               NREQ-1 back to 0; the lowest requesting index at or after
//               the pointer wins. The pointer moves to winner+1 on upd.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset (pointer -> 0)
//               req    - per-requester request vector
//               upd    - accept the current winner and advance the pointer
//               winner - combinational id of the round-robin winner
// Revision    : 1.0 - initial release
// ============================================================================
module sm_rr_arbiter
    import sm_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              upd,
    output logic [IDW-1:0]    winner
);

    localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0] r_ptr;
    logic           w_found;

    // Two passes: first requesters at/after the pointer, then the wrapped
    // part below it. Constant indices keep the search free of modulo logic.
    always_comb begin
        w_found = 1'b0;
        winner  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && req[j] && (IDW'(j) >= r_ptr)) begin
                w_found = 1'b1;
                winner  = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                winner  = IDW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (upd) begin
            r_ptr <= (winner == c_LAST_ID) ? '0 : winner + IDW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sm_mult_scheduler
// Description : Shares one shift-add sequential multiplier datapath between
//               NREQ requesters. Arbitrates round-robin, steers the operand
//               mux, sequences load/add/shift strobes with a bit counter and
//               emits a one-cycle done pulse tagged with the owner id.
//               All outputs decode from state/owner registers only.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset
//               req     - per-requester request, held until its gnt bit
//               mr      - multiplier register contents from the datapath
//               gnt     - one-hot grant, only during the LOAD cycle
//               md_sel  - operand mux select (current/last owner id)
//               mdld    - load multiplicand register
//               mrld    - load multiplier register
//               rsclear - clear running sum
//               rsload  - running sum += multiplicand << WIDTH
//               rsshr   - running sum >>= 1
//               busy    - high whenever not idle
//               done    - one-cycle pulse, running sum holds the product
//               done_id - owner id while done, otherwise 0
// Revision    : 1.0 - initial release
// ============================================================================
module sm_mult_scheduler
    import sm_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 2,
    localparam int IDW   = clog2_min1(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [WIDTH-1:0]  mr,
    output logic [NREQ-1:0]   gnt,
    output logic [IDW-1:0]    md_sel,
    output logic              mdld,
    output logic              mrld,
    output logic              rsclear,
    output logic              rsload,
    output logic              rsshr,
    output logic              busy,
    output logic              done,
    output logic [IDW-1:0]    done_id
);

    localparam int             CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  w_win;
    logic            w_arb_upd;
    logic            w_mr_bit;

    sm_rr_arbiter #(
        .NREQ   (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .upd    (w_arb_upd),
        .winner (w_win)
    );

    // Multiplier bit under test; the datapath never shifts mr, so the
    // counter picks the bit instead.
    always_comb begin
        w_mr_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) begin
                w_mr_bit = mr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore output decode. w_arb_upd is internal only; no
    // port output depends on req combinationally.
    always_comb begin
        w_next    = r_state;
        w_arb_upd = 1'b0;
        gnt       = '0;
        md_sel    = r_owner;
        mdld      = 1'b0;
        mrld      = 1'b0;
        rsclear   = 1'b0;
        rsload    = 1'b0;
        rsshr     = 1'b0;
        busy      = (r_state != ST_IDLE);
        done      = 1'b0;
        done_id   = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_arb_upd = 1'b1;
                    w_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                for (int i = 0; i < NREQ; i++) begin
                    gnt[i] = (r_owner == IDW'(i));
                end
                mdld    = 1'b1;
                mrld    = 1'b1;
                rsclear = 1'b1;
                w_next  = ST_TEST;
            end
            ST_TEST: begin
                w_next = w_mr_bit ? ST_ADD : ST_SHIFT;
            end
            ST_ADD: begin
                rsload = 1'b1;
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                rsshr  = 1'b1;
                w_next = (r_cnt == c_CNT_LAST) ? ST_DONE : ST_TEST;
            end
            ST_DONE: begin
                done    = 1'b1;
                done_id = r_owner;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bit counter: cleared at job start, stops advancing on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_arb_upd) begin
            r_cnt <= '0;
        end else if ((r_state == ST_SHIFT) && (r_cnt != c_CNT_LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= '0;
        end else if (w_arb_upd) begin
            r_owner <= w_win;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_mult_scheduler
// Description : Self-checking bench for sm_mult_scheduler (WIDTH=4, NREQ=2)
//               with a shift-add datapath model and a job-plan reference
//               model compared against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_mult_scheduler;

    localparam int W = 4;
    localparam int N = 2;

    localparam int P_LOAD  = 0;
    localparam int P_TEST  = 1;
    localparam int P_ADD   = 2;
    localparam int P_SHIFT = 3;
    localparam int P_DONE  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [3:0]   mr;
    logic [1:0]   gnt;
    logic [0:0]   md_sel;
    logic         mdld, mrld, rsclear, rsload, rsshr, busy, done;
    logic [0:0]   done_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm_mult_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mr      (mr),
        .gnt     (gnt),
        .md_sel  (md_sel),
        .mdld    (mdld),
        .mrld    (mrld),
        .rsclear (rsclear),
        .rsload  (rsload),
        .rsshr   (rsshr),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    // Requester operands and datapath model (running sum keeps a carry bit)
    logic [3:0] op_a [2];
    logic [3:0] op_b [2];
    logic [3:0] dp_md, dp_mr;
    logic [8:0] dp_rs;
    assign mr = dp_mr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_md <= '0;
            dp_mr <= '0;
            dp_rs <= '0;
        end else begin
            if (mdld) dp_md <= op_a[md_sel];
            if (mrld) dp_mr <= op_b[md_sel];
            if (rsclear)     dp_rs <= '0;
            else if (rsload) dp_rs <= dp_rs + ({5'd0, dp_md} << 4);
            else if (rsshr)  dp_rs <= dp_rs >> 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] outs();
        return {gnt, md_sel, mdld, mrld, rsclear, rsload, rsshr, busy, done, done_id};
    endfunction

    // Reference model: a job becomes a list of cycle actions built from the
    // multiplier bits; one action is consumed per clock.
    int plan[$];
    int m_owner = 0;
    int m_ptr   = 0;
    int m_prod  = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            plan.delete();
            m_owner = 0;
            m_ptr   = 0;
        end else if (plan.size() != 0) begin
            void'(plan.pop_front());
        end else if (req != 2'b00) begin
            int w;
            w = -1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (w < 0 && req[k]) w = k;
            end
            m_owner = w;
            m_ptr   = (w + 1) % N;
            m_prod  = int'(op_a[w]) * int'(op_b[w]);
            plan.push_back(P_LOAD);
            for (int b = 0; b < W; b++) begin
                plan.push_back(P_TEST);
                if (op_b[w][b]) plan.push_back(P_ADD);
                plan.push_back(P_SHIFT);
            end
            plan.push_back(P_DONE);
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        logic [1:0] eg;
        logic       eld, eadd, eshr, ebusy, edone;
        logic [0:0] esel, eid;
        int         act;
        @(negedge clk);
        eg = 2'b00; eld = 0; eadd = 0; eshr = 0; ebusy = 0; edone = 0;
        esel = 1'(m_owner);
        eid  = 1'b0;
        act  = (plan.size() != 0) ? plan[0] : -1;
        if (act >= 0) ebusy = 1'b1;
        case (act)
            P_LOAD:  begin eg = 2'(1 << m_owner); eld = 1'b1; end
            P_ADD:   eadd = 1'b1;
            P_SHIFT: eshr = 1'b1;
            P_DONE:  begin edone = 1'b1; eid = 1'(m_owner); end
            default: ;
        endcase
        chk("cycle_outputs", 32'(outs()),
            32'({eg, esel, eld, eld, eld, eadd, eshr, ebusy, edone, eid}));
        if (act == P_DONE) chk("model_product", 32'(dp_rs[7:0]), 32'(m_prod[7:0]));
    end

    // Runs one job with request mask r; reports grant id, latency, done_id,
    // product and strobe counts seen between grant and done.
    task automatic run_job(input logic [1:0] r, output int gid, output int lat,
                           output int did, output int prod, output int nload,
                           output int nshr);
        int  gcyc;
        bit  ok;
        gid = -1; lat = -1; did = -1; prod = -1; nload = 0; nshr = 0;
        req = r;
        ok  = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                ok   = 1;
                gid  = gnt[1] ? 1 : 0;
                gcyc = cyc;
            end
        end
        req = 2'b00;
        if (!ok) begin
            chk("gnt_timeout", 0, 1);
            return;
        end
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rsload) nload++;
            if (rsshr)  nshr++;
            if (done) begin
                ok   = 1;
                lat  = cyc - gcyc;
                did  = int'(done_id);
                prod = int'(dp_rs[7:0]);
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int gid, lat, did, prod, nl, ns, ngnt, ndone, n;
        int ids[4];
        bit ok;
        rst = 1'b1;
        req = 2'b00;
        op_a[0] = 4'h0; op_a[1] = 4'h0; op_b[0] = 4'h0; op_b[1] = 4'h0;
        #1;
        chk("reset_outputs", 32'(outs()), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // 1: 3 x 0 from requester 0
        op_a[0] = 4'h3; op_b[0] = 4'h0;
        run_job(2'b01, gid, lat, did, prod, nl, ns);
        chk("t1_gid", gid, 0);
        chk("t1_latency", lat, 9);
        chk("t1_done_id", did, 0);
        chk("t1_product", prod, 0);
        chk("t1_rsload", nl, 0);

        // 2: F x F from requester 1
        op_a[1] = 4'hF; op_b[1] = 4'hF;
        run_job(2'b10, gid, lat, did, prod, nl, ns);
        chk("t2_gid", gid, 1);
        chk("t2_latency", lat, 13);
        chk("t2_rsload", nl, 4);
        chk("t2_rsshr", ns, 4);
        chk("t2_product", prod, 32'hE1);
        chk("t2_done_id", did, 1);

        // 3: both requesting continuously -> alternating grants
        op_a[0] = 4'h2; op_b[0] = 4'h3; op_a[1] = 4'h4; op_b[1] = 4'h9;
        req = 2'b11;
        n = 0;
        for (int k = 0; k < 200 && n < 4; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                ids[n] = gnt[1] ? 1 : 0;
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("t3_grant_count", n, 4);
        for (int i = 0; i < 4; i++) chk("t3_grant_order", (i < n) ? ids[i] : -1, i % 2);
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        chk("t3_last_done", ok, 1);

        // 4: request pulsed during busy is ignored
        op_a[0] = 4'h1; op_b[0] = 4'h1;
        req = 2'b01;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) ok = 1;
        end
        req = 2'b00;
        chk("t4_first_gnt", ok, 1);
        repeat (3) @(negedge clk);
        req = 2'b10;
        repeat (2) @(negedge clk);
        req = 2'b00;
        ngnt = 0; ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) ngnt++;
            if (done) ndone++;
        end
        chk("t4_extra_gnt", ngnt, 0);
        chk("t4_done_count", ndone, 1);
        chk("t4_idle_busy", busy, 0);

        // 5: async reset in the middle of a SHIFT cycle
        op_a[0] = 4'h5; op_b[0] = 4'h6;
        req = 2'b01;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) ok = 1;
        end
        req = 2'b00;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rsshr) ok = 1;
        end
        chk("t5_saw_shift", ok, 1);
        #1 rst = 1'b1;
        #1 chk("t5_async_clear", 32'(outs()), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        run_job(2'b11, gid, lat, did, prod, nl, ns);
        chk("t5_gid_after_rst", gid, 0);
        chk("t5_product", prod, 32'h1E);
        chk("t5_latency", lat, 11);

        // 6: 7 x 5 from requester 1
        op_a[1] = 4'h7; op_b[1] = 4'h5;
        run_job(2'b10, gid, lat, did, prod, nl, ns);
        chk("t6_gid", gid, 1);
        chk("t6_latency", lat, 11);
        chk("t6_rsload", nl, 2);
        chk("t6_product", prod, 32'h23);
        chk("t6_done_id", did, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
